// File: rtl/buffer_read_ctrl.sv
// buffer_read_ctrl: write/read pointer and handshake controller for a
// circular line buffer. The writer side accepts PAR_WRITE words per beat.
// The reader side drains PAR_READ words per beat into a registered
// valid/ready output stage. Parameters must satisfy
// 1 <= PAR_WRITE <= DEPTH and 1 <= PAR_READ <= DEPTH.
module buffer_read_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int PAR_WRITE  = 1,
  parameter int PAR_READ   = 1,
  parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  output logic                           buf_wen,
  output logic [ADDR_WIDTH-1:0]          buf_waddr,
  output logic [ADDR_WIDTH-1:0]          buf_raddr,
  input  logic [PAR_READ*DATA_WIDTH-1:0] buf_dout,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [PAR_READ*DATA_WIDTH-1:0] rd_data,
  output logic [CNT_WIDTH-1:0]           occupancy
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  // Pointer sums need one extra bit so the wrap test cannot overflow.
  localparam logic [ADDR_WIDTH:0]  DEPTH_A  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]  PW_A     = (ADDR_WIDTH+1)'(PAR_WRITE);
  localparam logic [ADDR_WIDTH:0]  PR_A     = (ADDR_WIDTH+1)'(PAR_READ);
  localparam logic [CNT_WIDTH-1:0] PW_C     = CNT_WIDTH'(PAR_WRITE);
  localparam logic [CNT_WIDTH-1:0] PR_C     = CNT_WIDTH'(PAR_READ);
  localparam logic [CNT_WIDTH-1:0] WR_LIMIT = CNT_WIDTH'(DEPTH - PAR_WRITE);

  state_t                         state, state_next;
  logic [ADDR_WIDTH-1:0]          wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [ADDR_WIDTH-1:0]          wr_inc, rd_inc;
  logic [ADDR_WIDTH:0]            wr_sum, rd_sum;
  logic [CNT_WIDTH-1:0]           occ_next;
  logic [PAR_READ*DATA_WIDTH-1:0] rd_data_next;
  logic                           push, load;

  // Write credit ignores a same-cycle pop so wr_ready never depends on rd_ready.
  assign wr_ready  = (occupancy <= WR_LIMIT);
  assign push      = wr_valid & wr_ready & ~flush;
  // Load only from registered occupancy, so freshly written words are never read.
  assign load      = (~rd_valid | rd_ready) & (occupancy >= PR_C) & ~flush;
  assign buf_wen   = push;
  assign buf_waddr = wr_ptr;
  assign buf_raddr = rd_ptr;
  assign rd_valid  = (state == ST_FULL);

  // Base addresses wrap by subtraction so DEPTH need not be a power of two.
  assign wr_sum = {1'b0, wr_ptr} + PW_A;
  assign rd_sum = {1'b0, rd_ptr} + PR_A;
  assign wr_inc = (wr_sum >= DEPTH_A) ? ADDR_WIDTH'(wr_sum - DEPTH_A) : ADDR_WIDTH'(wr_sum);
  assign rd_inc = (rd_sum >= DEPTH_A) ? ADDR_WIDTH'(rd_sum - DEPTH_A) : ADDR_WIDTH'(rd_sum);

  // Next-state logic: flush wins, otherwise push and load apply independently.
  always_comb begin
    state_next   = state;
    wr_ptr_next  = wr_ptr;
    rd_ptr_next  = rd_ptr;
    occ_next     = occupancy;
    rd_data_next = rd_data;
    if (flush) begin
      state_next   = ST_EMPTY;
      wr_ptr_next  = '0;
      rd_ptr_next  = '0;
      occ_next     = '0;
      rd_data_next = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_inc;
      end
      if (load) begin
        rd_ptr_next  = rd_inc;
        rd_data_next = buf_dout;
      end
      occ_next = occupancy + (push ? PW_C : '0) - (load ? PR_C : '0);
      case (state)
        ST_EMPTY: if (load) state_next = ST_FULL;
        ST_FULL:  if (rd_ready && !load) state_next = ST_EMPTY;
        default:  state_next = ST_EMPTY;
      endcase
    end
  end

  // State register: pointers, occupancy and the output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      rd_data   <= '0;
    end else begin
      state     <= state_next;
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      occupancy <= occ_next;
      rd_data   <= rd_data_next;
    end
  end

endmodule

// File: tb/tb_buffer_read_ctrl.sv
// tb_buffer_read_ctrl: scoreboard bench for buffer_read_ctrl. Three
// instances cover DEPTH=4/PW=1/PR=1, DEPTH=4/PW=1/PR=2 and DEPTH=3/PW=2/PR=1,
// each with a small behavioural line buffer attached.
module tb_buffer_read_ctrl;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   occ_viol;

  // Instance A: DEPTH=4, PAR_WRITE=1, PAR_READ=1
  logic        a_flush, a_wr_valid, a_wr_ready, a_buf_wen, a_rd_valid, a_rd_ready;
  logic [1:0]  a_buf_waddr, a_buf_raddr;
  logic [15:0] a_buf_dout, a_rd_data, a_wr_word;
  logic [2:0]  a_occ;
  logic [15:0] mem_a [4];
  logic [15:0] exp_a [$];
  logic [15:0] obs_a [$];
  int          idx_a;

  // Instance B: DEPTH=4, PAR_WRITE=1, PAR_READ=2
  logic        b_flush, b_wr_valid, b_wr_ready, b_buf_wen, b_rd_valid, b_rd_ready;
  logic [1:0]  b_buf_waddr, b_buf_raddr;
  logic [31:0] b_buf_dout, b_rd_data;
  logic [15:0] b_wr_word;
  logic [2:0]  b_occ;
  logic [15:0] mem_b [4];
  logic [31:0] exp_b [$];
  logic [31:0] obs_b [$];
  int          idx_b;

  // Instance C: DEPTH=3, PAR_WRITE=2, PAR_READ=1
  logic        c_flush, c_wr_valid, c_wr_ready, c_buf_wen, c_rd_valid, c_rd_ready;
  logic [1:0]  c_buf_waddr, c_buf_raddr;
  logic [15:0] c_buf_dout, c_rd_data;
  logic [31:0] c_wr_pair;
  logic [1:0]  c_occ;
  logic [15:0] mem_c [3];
  logic [15:0] exp_c [$];
  logic [15:0] obs_c [$];
  int          idx_c;

  buffer_read_ctrl #(.DATA_WIDTH(16), .DEPTH(4), .PAR_WRITE(1), .PAR_READ(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_valid(a_wr_valid), .wr_ready(a_wr_ready),
    .buf_wen(a_buf_wen), .buf_waddr(a_buf_waddr), .buf_raddr(a_buf_raddr), .buf_dout(a_buf_dout),
    .rd_valid(a_rd_valid), .rd_ready(a_rd_ready), .rd_data(a_rd_data), .occupancy(a_occ));

  buffer_read_ctrl #(.DATA_WIDTH(16), .DEPTH(4), .PAR_WRITE(1), .PAR_READ(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .buf_wen(b_buf_wen), .buf_waddr(b_buf_waddr), .buf_raddr(b_buf_raddr), .buf_dout(b_buf_dout),
    .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_data(b_rd_data), .occupancy(b_occ));

  buffer_read_ctrl #(.DATA_WIDTH(16), .DEPTH(3), .PAR_WRITE(2), .PAR_READ(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush), .wr_valid(c_wr_valid), .wr_ready(c_wr_ready),
    .buf_wen(c_buf_wen), .buf_waddr(c_buf_waddr), .buf_raddr(c_buf_raddr), .buf_dout(c_buf_dout),
    .rd_valid(c_rd_valid), .rd_ready(c_rd_ready), .rd_data(c_rd_data), .occupancy(c_occ));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural line buffers: write at posedge, combinational wrapped read.
  always @(posedge clk) begin
    if (a_buf_wen) mem_a[a_buf_waddr] <= a_wr_word;
    if (b_buf_wen) mem_b[b_buf_waddr] <= b_wr_word;
    if (c_buf_wen) begin
      mem_c[c_buf_waddr]                    <= c_wr_pair[15:0];
      mem_c[(int'(c_buf_waddr) + 1) % 3]    <= c_wr_pair[31:16];
    end
  end
  assign a_buf_dout = mem_a[a_buf_raddr];
  assign b_buf_dout = {mem_b[b_buf_raddr + 2'd1], mem_b[b_buf_raddr]};
  assign c_buf_dout = mem_c[c_buf_raddr];

  // Output monitor: record every accepted beat and flag occupancy overflow.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_rd_valid && a_rd_ready) obs_a.push_back(a_rd_data);
      if (b_rd_valid && b_rd_ready) obs_b.push_back(b_rd_data);
      if (c_rd_valid && c_rd_ready) obs_c.push_back(c_rd_data);
      if (a_occ > 3'd4 || b_occ > 3'd4) occ_viol <= occ_viol + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_flush = 0; a_wr_valid = 0; a_rd_ready = 0; a_wr_word = '0;
    b_flush = 0; b_wr_valid = 0; b_rd_ready = 0; b_wr_word = '0;
    c_flush = 0; c_wr_valid = 0; c_rd_ready = 0; c_wr_pair = '0;
    idx_a = 0; idx_b = 0; idx_c = 0;
    #1;
    tests++; if (a_wr_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_wr_ready: got %0d want 1", a_wr_ready); end
    tests++; if (a_rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rd_valid: got %0d want 0", a_rd_valid); end
    tests++; if (a_occ !== 3'd0) begin fails++; $display("[TB] FAIL reset_occ: got %0d want 0", a_occ); end
    tests++; if (a_buf_waddr !== 2'd0 || a_buf_raddr !== 2'd0) begin fails++; $display("[TB] FAIL reset_ptrs: got w=%0d r=%0d want 0 0", a_buf_waddr, a_buf_raddr); end
    tests++; if (a_rd_data !== 16'd0) begin fails++; $display("[TB] FAIL reset_rd_data: got %0h want 0", a_rd_data); end
    tests++; if (b_wr_ready !== 1'b1 || c_wr_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_wr_ready_bc: got %0d %0d want 1 1", b_wr_ready, c_wr_ready); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_push();
    logic [15:0] e;
    tick();
    a_wr_valid = 1; a_wr_word = 16'd5; exp_a.push_back(16'd5);
    #1;
    tests++; if (a_buf_wen !== 1'b1 || a_buf_waddr !== 2'd0) begin fails++; $display("[TB] FAIL single_wen: got wen=%0d waddr=%0d want 1 0", a_buf_wen, a_buf_waddr); end
    tick();
    a_wr_valid = 0;
    #1;
    tests++; if (a_occ !== 3'd1 || a_rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_after_e1: got occ=%0d valid=%0d want 1 0", a_occ, a_rd_valid); end
    tick();
    #1;
    tests++; if (a_rd_valid !== 1'b1 || a_rd_data !== 16'd5 || a_occ !== 3'd0) begin fails++; $display("[TB] FAIL single_after_e2: got valid=%0d data=%0d occ=%0d want 1 5 0", a_rd_valid, a_rd_data, a_occ); end
    a_rd_ready = 1;
    tick();
    a_rd_ready = 0;
    #1;
    tests++; if (a_rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_drained: got valid=%0d want 0", a_rd_valid); end
    tests++; if (obs_a.size() - idx_a !== exp_a.size()) begin fails++; $display("[TB] FAIL single_count: got %0d beats want %0d", obs_a.size() - idx_a, exp_a.size()); end
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      if (idx_a < obs_a.size()) begin
        tests++; if (obs_a[idx_a] !== e) begin fails++; $display("[TB] FAIL single_data: got %0d want %0d", obs_a[idx_a], e); end
        idx_a++;
      end
    end
  endtask

  task automatic test_fill_full();
    logic [15:0] e;
    int v;
    a_rd_ready = 0; v = 1;
    for (int c = 0; c < 8; c++) begin
      a_wr_valid = (v <= 6); a_wr_word = 16'(v);
      #1;
      if (c == 5) begin
        tests++; if (a_wr_ready !== 1'b0 || a_buf_wen !== 1'b0) begin fails++; $display("[TB] FAIL fill_full_ready: got ready=%0d wen=%0d want 0 0", a_wr_ready, a_buf_wen); end
        tests++; if (a_occ !== 3'd4) begin fails++; $display("[TB] FAIL fill_full_occ: got %0d want 4", a_occ); end
        tests++; if (a_rd_valid !== 1'b1 || a_rd_data !== 16'd1) begin fails++; $display("[TB] FAIL fill_first_out: got valid=%0d data=%0d want 1 1", a_rd_valid, a_rd_data); end
      end
      if (a_wr_valid && a_wr_ready) begin exp_a.push_back(16'(v)); v++; end
      tick();
    end
    tests++; if (v !== 6) begin fails++; $display("[TB] FAIL fill_blocked: got next value %0d want 6", v); end
    a_rd_ready = 1;
    #1;
    tests++; if (a_wr_ready !== 1'b0) begin fails++; $display("[TB] FAIL fill_pop_not_credited: got ready=%0d want 0", a_wr_ready); end
    for (int c = 0; c < 12; c++) begin
      a_wr_valid = (v <= 6); a_wr_word = 16'(v);
      #1;
      if (a_wr_valid && a_wr_ready) begin exp_a.push_back(16'(v)); v++; end
      tick();
    end
    a_wr_valid = 0; a_rd_ready = 0;
    #1;
    tests++; if (a_occ !== 3'd0 || a_rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL fill_drained: got occ=%0d valid=%0d want 0 0", a_occ, a_rd_valid); end
    tests++; if (obs_a.size() - idx_a !== 6) begin fails++; $display("[TB] FAIL fill_count: got %0d beats want 6", obs_a.size() - idx_a); end
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      if (idx_a < obs_a.size()) begin
        tests++; if (obs_a[idx_a] !== e) begin fails++; $display("[TB] FAIL fill_data: got %0d want %0d", obs_a[idx_a], e); end
        idx_a++;
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] e;
    a_rd_ready = 0;
    for (int c = 0; c < 4; c++) begin
      a_wr_valid = 1; a_wr_word = 16'(100 + c); exp_a.push_back(16'(100 + c));
      tick();
    end
    a_wr_valid = 1; a_wr_word = 16'd104; a_rd_ready = 1; exp_a.push_back(16'd104);
    #1;
    tests++; if (a_occ !== 3'd3 || a_buf_wen !== 1'b1) begin fails++; $display("[TB] FAIL simul_before: got occ=%0d wen=%0d want 3 1", a_occ, a_buf_wen); end
    tick();
    a_wr_valid = 0; a_rd_ready = 0;
    #1;
    tests++; if (a_occ !== 3'd3 || a_rd_data !== 16'd101) begin fails++; $display("[TB] FAIL simul_after: got occ=%0d data=%0d want 3 101", a_occ, a_rd_data); end
    a_rd_ready = 1;
    for (int c = 0; c < 8; c++) tick();
    a_rd_ready = 0;
    tests++; if (obs_a.size() - idx_a !== exp_a.size()) begin fails++; $display("[TB] FAIL simul_count: got %0d beats want %0d", obs_a.size() - idx_a, exp_a.size()); end
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      if (idx_a < obs_a.size()) begin
        tests++; if (obs_a[idx_a] !== e) begin fails++; $display("[TB] FAIL simul_data: got %0d want %0d", obs_a[idx_a], e); end
        idx_a++;
      end
    end
  endtask

  task automatic test_flush_and_reset();
    logic [15:0] e;
    a_rd_ready = 0;
    for (int c = 0; c < 4; c++) begin
      a_wr_valid = 1; a_wr_word = 16'(200 + c);
      tick();
    end
    a_flush = 1; a_wr_valid = 1; a_wr_word = 16'd99;
    #1;
    tests++; if (a_occ !== 3'd3 || a_rd_valid !== 1'b1) begin fails++; $display("[TB] FAIL flush_setup: got occ=%0d valid=%0d want 3 1", a_occ, a_rd_valid); end
    tests++; if (a_buf_wen !== 1'b0) begin fails++; $display("[TB] FAIL flush_wen: got %0d want 0", a_buf_wen); end
    tick();
    a_flush = 0; a_wr_valid = 0;
    #1;
    tests++; if (a_rd_valid !== 1'b0 || a_occ !== 3'd0 || a_rd_data !== 16'd0) begin fails++; $display("[TB] FAIL flush_state: got valid=%0d occ=%0d data=%0d want 0 0 0", a_rd_valid, a_occ, a_rd_data); end
    tests++; if (a_buf_waddr !== 2'd0 || a_buf_raddr !== 2'd0) begin fails++; $display("[TB] FAIL flush_ptrs: got w=%0d r=%0d want 0 0", a_buf_waddr, a_buf_raddr); end
    exp_a.delete(); idx_a = obs_a.size();
    a_wr_valid = 1; a_wr_word = 16'd7; exp_a.push_back(16'd7);
    tick();
    a_wr_valid = 0; a_rd_ready = 1;
    for (int c = 0; c < 4; c++) tick();
    a_rd_ready = 0;
    tests++; if (obs_a.size() - idx_a !== 1) begin fails++; $display("[TB] FAIL flush_resume_count: got %0d beats want 1", obs_a.size() - idx_a); end
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      if (idx_a < obs_a.size()) begin
        tests++; if (obs_a[idx_a] !== e) begin fails++; $display("[TB] FAIL flush_resume_data: got %0d want %0d", obs_a[idx_a], e); end
        idx_a++;
      end
    end
    for (int c = 0; c < 4; c++) begin
      a_wr_valid = 1; a_wr_word = 16'(300 + c);
      tick();
    end
    a_wr_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (a_rd_valid !== 1'b0 || a_occ !== 3'd0 || a_rd_data !== 16'd0) begin fails++; $display("[TB] FAIL async_state: got valid=%0d occ=%0d data=%0d want 0 0 0", a_rd_valid, a_occ, a_rd_data); end
    tests++; if (a_buf_waddr !== 2'd0 || a_buf_raddr !== 2'd0) begin fails++; $display("[TB] FAIL async_ptrs: got w=%0d r=%0d want 0 0", a_buf_waddr, a_buf_raddr); end
    rst_n = 1'b1;
    exp_a.delete(); idx_a = obs_a.size();
  endtask

  task automatic test_parallel_wrap();
    logic [31:0] e;
    int v;
    tick();
    b_rd_ready = 1; v = 0;
    for (int c = 0; c < 12; c++) begin
      b_wr_valid = (v < 6); b_wr_word = 16'(10 * (v + 1));
      #1;
      if (c == 6) begin
        tests++; if (b_buf_raddr !== 2'd0 || b_occ !== 3'd2) begin fails++; $display("[TB] FAIL wrap_third_beat: got raddr=%0d occ=%0d want 0 2", b_buf_raddr, b_occ); end
      end
      if (b_wr_valid && b_wr_ready) begin
        if (v % 2 == 1) exp_b.push_back({16'(10 * (v + 1)), 16'(10 * v)});
        v++;
      end
      tick();
    end
    b_wr_valid = 0; b_rd_ready = 0;
    #1;
    tests++; if (b_buf_raddr !== 2'd2 || b_buf_waddr !== 2'd2 || b_occ !== 3'd0) begin fails++; $display("[TB] FAIL wrap_end: got r=%0d w=%0d occ=%0d want 2 2 0", b_buf_raddr, b_buf_waddr, b_occ); end
    tests++; if (obs_b.size() - idx_b !== 3) begin fails++; $display("[TB] FAIL wrap_count: got %0d beats want 3", obs_b.size() - idx_b); end
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      if (idx_b < obs_b.size()) begin
        tests++; if (obs_b[idx_b] !== e) begin fails++; $display("[TB] FAIL wrap_data: got %08h want %08h", obs_b[idx_b], e); end
        idx_b++;
      end
    end
  endtask

  task automatic test_non_pow2();
    logic [15:0] e;
    int p;
    int wtab [6] = '{0, 2, 2, 1, 1, 1};
    int rtab [6] = '{0, 0, 1, 2, 0, 1};
    c_rd_ready = 1; p = 0;
    for (int c = 0; c < 8; c++) begin
      c_wr_valid = (p < 2); c_wr_pair = (p == 0) ? 32'h0002_0001 : 32'h0004_0003;
      #1;
      if (c < 6) begin
        tests++; if (int'(c_buf_waddr) !== wtab[c] || int'(c_buf_raddr) !== rtab[c]) begin fails++; $display("[TB] FAIL npot_ptrs c%0d: got w=%0d r=%0d want %0d %0d", c, c_buf_waddr, c_buf_raddr, wtab[c], rtab[c]); end
      end
      if (c == 1) begin
        tests++; if (c_wr_ready !== 1'b0) begin fails++; $display("[TB] FAIL npot_ready_limit: got %0d want 0", c_wr_ready); end
      end
      if (c_wr_valid && c_wr_ready) begin
        exp_c.push_back(c_wr_pair[15:0]); exp_c.push_back(c_wr_pair[31:16]); p++;
      end
      tick();
    end
    c_wr_valid = 0; c_rd_ready = 0;
    tests++; if (obs_c.size() - idx_c !== 4) begin fails++; $display("[TB] FAIL npot_count: got %0d beats want 4", obs_c.size() - idx_c); end
    while (exp_c.size() > 0) begin
      e = exp_c.pop_front();
      if (idx_c < obs_c.size()) begin
        tests++; if (obs_c[idx_c] !== e) begin fails++; $display("[TB] FAIL npot_data: got %0d want %0d", obs_c[idx_c], e); end
        idx_c++;
      end
    end
  endtask

  task automatic test_occupancy_bound();
    tests++; if (occ_viol !== 0) begin fails++; $display("[TB] FAIL occ_bound: got %0d violations want 0", occ_viol); end
  endtask

  initial begin
    tests = 0; fails = 0; occ_viol = 0;
    test_reset();
    test_single_push();
    test_fill_full();
    test_simultaneous();
    test_flush_and_reset();
    test_parallel_wrap();
    test_non_pow2();
    test_occupancy_bound();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/buffer_read_ctrl.md
Name: buffer_read_ctrl

Overview:
Pointer and handshake controller that owns both ends of a circular line buffer with parallel write and parallel read ports. On the writer side it accepts PAR_WRITE words per beat and drives the buffer's write enable and write address. On the reader side it drains PAR_READ consecutive words per beat into a registered valid/ready output stage. It sits between a producer stage and a PE/consumer stage, and supplies the buffer's wen/waddr/raddr signals, which the buffer itself does not manage.

Parameters:
DATA_WIDTH, 16, width of one buffer word (signed)
DEPTH, 4, buffer entries; need not be a power of two
PAR_WRITE, 1, words written per accepted write beat; must satisfy 1 <= PAR_WRITE <= DEPTH
PAR_READ, 1, words popped per read beat; must satisfy 1 <= PAR_READ <= DEPTH
ADDR_WIDTH, $clog2(DEPTH), buffer address width
CNT_WIDTH, $clog2(DEPTH+1), occupancy counter width

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of pointers, occupancy and output stage
wr_valid  input  1  producer offers PAR_WRITE words
wr_ready  output  1  controller can accept one write beat
buf_wen  output  1  buffer write enable; equals wr_valid & wr_ready & ~flush
buf_waddr  output  ADDR_WIDTH  buffer write base address (write pointer)
buf_raddr  output  ADDR_WIDTH  buffer read base address (read pointer)
buf_dout  input  PAR_READ*DATA_WIDTH  combinational read data from the buffer at buf_raddr
rd_valid  output  1  rd_data holds a valid beat
rd_ready  input  1  consumer accepts rd_data
rd_data  output  PAR_READ*DATA_WIDTH  registered read beat; word i is at bits [i*DATA_WIDTH +: DATA_WIDTH]
occupancy  output  CNT_WIDTH  words held in the buffer; excludes the output register

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr=0, rd_ptr=0, occupancy=0, rd_valid=0, rd_data=0. wr_ready then follows combinationally from occupancy=0, so it is 1.
- wr_ready = (occupancy <= DEPTH-PAR_WRITE). The same-cycle pop is not credited; this is intentional, keeping wr_ready independent of rd_ready.
- push = wr_valid & wr_ready & ~flush.
  - On push, the buffer writes at this posedge.
  - wr_ptr <= (wr_ptr+PAR_WRITE) mod DEPTH. Non-power-of-two DEPTH: subtract DEPTH if the sum >= DEPTH; no % operator.
- Output stage has two states:
  - EMPTY (rd_valid=0).
  - FULL (rd_valid=1).
- load = (~rd_valid | rd_ready) & (occupancy >= PAR_READ) & ~flush.
  - On load: rd_data <= buf_dout; rd_valid <= 1; rd_ptr <= (rd_ptr+PAR_READ) mod DEPTH, same wrap rule as wr_ptr.
- Transitions:
  - FULL & rd_ready & ~load -> EMPTY.
  - EMPTY & load -> FULL.
  - FULL & rd_ready & load -> FULL with new data (back-to-back, one beat per cycle).
  - FULL & ~rd_ready: rd_data and rd_valid held stable.
- Occupancy update: occupancy <= occupancy + push*PAR_WRITE - load*PAR_READ. A simultaneous push and load both apply.
- Latency: data written at edge t is counted at t and is loadable at edge t+1. rd_valid rises after edge t+1, so the minimum write-to-rd_valid latency is 2 cycles.
- Because load uses the registered occupancy, the buffer is never read at addresses written in the same cycle.
- flush (synchronous):
  - Has priority over push and load.
  - Next state matches reset.
  - buf_wen is forced to 0 during flush.
- Reset asserted mid-beat: an in-flight rd_data is discarded; there is no partial-beat recovery.
- Wrap-around:
  - A beat may straddle the end of the buffer (e.g. rd_ptr=3, PAR_READ=2, DEPTH=4 reads entries 3,0). The buffer's read port handles the per-word wrap; the controller only wraps the base address.
- occupancy never exceeds DEPTH and never goes below 0. This holds by construction; the bench asserts it every cycle.
- PAR_READ > PAR_WRITE is legal. The controller accumulates write beats until occupancy >= PAR_READ.

Test Plan:
1. Reset then idle (DEPTH=4, PAR_W=1, PAR_R=1): after reset -> wr_ready=1, rd_valid=0, occupancy=0, buf_waddr=0, buf_raddr=0. Push 5 at cycle 0 -> buf_wen=1, buf_waddr=0; rd_valid=1 with rd_data=5 after the second edge.
2. Fill/full (DEPTH=4, PAR_W=1, rd_ready=0): push 1,2,3,4,5,6 -> first value loads to output; wr_ready=0 once occupancy=4 (values 2..5 buffered); 6 not accepted until rd_ready=1 pops a beat.
3. Parallel read with wrap (DEPTH=4, PAR_W=1, PAR_R=2): push 10,20,30,40,50,60, rd_ready=1 -> beats {20,10},{40,30},{60,50}. The third beat is read at buf_raddr=0 after the wrap.
4. Non-power-of-two (DEPTH=3, PAR_W=2, PAR_R=1): push {1,2},{3,4} while draining -> rd_data sequence 1,2,3,4. The write pointer goes 0->2->1 and the read pointer cycles 0,1,2,0.
5. Simultaneous push and pop at occupancy=DEPTH-PAR_W (DEPTH=4, PAR_W=1): one cycle with push and load -> occupancy unchanged; no data lost or duplicated (scoreboard).
6. Flush with rd_valid=1, occupancy=3, wr_valid=1 -> next cycle rd_valid=0, occupancy=0, both pointers 0, buf_wen=0 during the flush cycle. An asynchronous rst_n pulse mid-burst gives the same result immediately, without waiting for a clock edge.
